// File: rtl/register_mode_sequencer.sv
// register_mode_sequencer: steps through a small program of 2-bit mode codes,
// driving mode select S and data D to a 4-bit mode register for (LEN+1)*(REPEAT+1) cycles.
`default_nettype none

module register_mode_sequencer #(
    parameter int DEPTH = 8,
    parameter int DW    = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic          ABORT,
    input  logic          PROG_WE,
    input  logic [AW-1:0] PROG_ADDR,
    input  logic [1:0]    PROG_DATA,
    input  logic [AW-1:0] LEN,
    input  logic [3:0]    REPEAT,
    input  logic [DW-1:0] D_IN,
    output logic [1:0]    S,
    output logic [DW-1:0] D,
    output logic [AW-1:0] STEP,
    output logic [3:0]    PASS,
    output logic          BUSY,
    output logic          DONE,
    output logic          ABORTED
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] step_q, step_d;
    logic [AW-1:0] len_q, len_d;
    logic [3:0]    pass_q, pass_d;
    logic [3:0]    rep_q, rep_d;
    logic [DW-1:0] d_q, d_d;
    logic          aborted_q, aborted_d;
    logic          prog_en;

    // Program writes are only accepted while idle; a write coinciding with
    // START commits on the same edge, so the first RUN cycle already sees it.
    assign prog_en = PROG_WE && (state_q == ST_IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else if (prog_en) begin
            mem_q[PROG_ADDR] <= PROG_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            len_q     <= '0;
            pass_q    <= '0;
            rep_q     <= '0;
            d_q       <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            len_q     <= len_d;
            pass_q    <= pass_d;
            rep_q     <= rep_d;
            d_q       <= d_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        len_d     = len_q;
        pass_d    = pass_q;
        rep_d     = rep_q;
        d_d       = d_q;
        aborted_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                    pass_d  = '0;
                    len_d   = LEN;
                    rep_d   = REPEAT;
                    d_d     = D_IN;
                end
            end
            ST_RUN: begin
                // Abort outranks the final-step transition to FIN.
                if (ABORT) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (step_q < len_q) begin
                    step_d = step_q + 1'b1;
                end else if (pass_q < rep_q) begin
                    step_d = '0;
                    pass_d = pass_q + 1'b1;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign S       = (state_q == ST_RUN) ? mem_q[step_q] : 2'b00;
    assign D       = d_q;
    assign STEP    = step_q;
    assign PASS    = pass_q;
    assign BUSY    = (state_q == ST_RUN);
    assign DONE    = (state_q == ST_FIN);
    assign ABORTED = aborted_q;

endmodule

`default_nettype wire

// File: tb/tb_register_mode_sequencer.sv
// Self-checking bench: directed and random runs compared against a program-list model.
`default_nettype none

module tb_register_mode_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START, ABORT, PROG_WE;
    logic [2:0] PROG_ADDR;
    logic [1:0] PROG_DATA;
    logic [2:0] LEN;
    logic [3:0] REPEAT;
    logic [3:0] D_IN;
    logic [1:0] S;
    logic [3:0] D;
    logic [2:0] STEP;
    logic [3:0] PASS;
    logic       BUSY, DONE, ABORTED;

    int checks = 0;
    int fails  = 0;
    logic [1:0] model_mem [8];

    register_mode_sequencer #(.DEPTH(8), .DW(4)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
        .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
        .LEN(LEN), .REPEAT(REPEAT), .D_IN(D_IN),
        .S(S), .D(D), .STEP(STEP), .PASS(PASS),
        .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic prog(input int addr, input logic [1:0] data);
        PROG_WE = 1'b1; PROG_ADDR = addr[2:0]; PROG_DATA = data;
        tick();
        PROG_WE = 1'b0;
        model_mem[addr] = data;
    endtask

    // Expected behaviour: the run visits step indices 0..len once per pass,
    // for rep+1 passes, emitting the stored mode code of each step.
    task automatic do_run(input int len, input int rep, input logic [3:0] din,
                          input int abort_at, input int wr_at,
                          input bit coin_wr, input logic [1:0] coin_data, input bit noise);
        int total;
        if (coin_wr) begin
            PROG_WE = 1'b1; PROG_ADDR = 3'd0; PROG_DATA = coin_data;
            model_mem[0] = coin_data;
        end
        START = 1'b1; LEN = len[2:0]; REPEAT = rep[3:0]; D_IN = din;
        tick();
        START = 1'b0; PROG_WE = 1'b0;
        total = (len + 1) * (rep + 1);
        for (int i = 0; i < total; i++) begin
            int st;
            int ps;
            st = i % (len + 1);
            ps = i / (len + 1);
            chk("run_busy", BUSY, 1);
            chk("run_s", S, model_mem[st]);
            chk("run_step", STEP, st);
            chk("run_pass", PASS, ps);
            chk("run_d", D, din);
            chk("run_done", DONE, 0);
            chk("run_aborted", ABORTED, 0);
            if (noise) begin
                START = 1'($urandom_range(0, 1));
                D_IN  = 4'($urandom);
            end
            if (i == wr_at) begin
                PROG_WE = 1'b1; PROG_ADDR = 3'd0; PROG_DATA = 2'b11;
            end
            if (i == abort_at) begin
                ABORT = 1'b1;
                tick();
                ABORT = 1'b0; START = 1'b0; PROG_WE = 1'b0;
                chk("abort_busy", BUSY, 0);
                chk("abort_s", S, 0);
                chk("abort_pulse", ABORTED, 1);
                chk("abort_done", DONE, 0);
                chk("abort_d", D, din);
                tick();
                chk("abort_pulse_end", ABORTED, 0);
                chk("abort_no_done", DONE, 0);
                chk("abort_idle_busy", BUSY, 0);
                return;
            end
            tick();
            START = 1'b0; PROG_WE = 1'b0;
        end
        chk("fin_done", DONE, 1);
        chk("fin_busy", BUSY, 0);
        chk("fin_s", S, 0);
        chk("fin_step", STEP, len);
        chk("fin_pass", PASS, rep);
        chk("fin_d", D, din);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("idle_done", DONE, 0);
        chk("idle_busy", BUSY, 0);
        chk("idle_aborted", ABORTED, 0);
        chk("idle_step_hold", STEP, len);
        chk("idle_pass_hold", PASS, rep);
        chk("idle_s", S, 0);
    endtask

    initial begin
        RESET = 1'b0; START = 1'b0; ABORT = 1'b0; PROG_WE = 1'b0;
        PROG_ADDR = '0; PROG_DATA = '0; LEN = '0; REPEAT = '0; D_IN = '0;
        for (int i = 0; i < 8; i++) model_mem[i] = 2'b00;
        #1;
        chk("rst_s", S, 0);
        chk("rst_d", D, 0);
        chk("rst_step", STEP, 0);
        chk("rst_pass", PASS, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_aborted", ABORTED, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        // Single-step program repeated twice.
        prog(0, 2'b01);
        do_run(0, 1, 4'b1101, -1, -1, 1'b0, 2'b00, 1'b0);

        // Four-step program, one pass.
        prog(0, 2'b00); prog(1, 2'b01); prog(2, 2'b10); prog(3, 2'b11);
        do_run(3, 0, 4'b0110, -1, -1, 1'b0, 2'b00, 1'b0);

        // Two steps, three passes.
        do_run(1, 2, 4'b1010, -1, -1, 1'b0, 2'b00, 1'b0);

        // Abort on the second RUN cycle.
        do_run(3, 0, 4'b0011, 1, -1, 1'b0, 2'b00, 1'b0);

        // Abort coinciding with the final step.
        do_run(1, 0, 4'b0101, 1, -1, 1'b0, 2'b00, 1'b0);

        // Program write during RUN is ignored; second pass re-reads mem[0].
        do_run(3, 1, 4'b1111, -1, 0, 1'b0, 2'b00, 1'b0);

        // Write coinciding with START commits and is seen by the run.
        do_run(2, 0, 4'b1001, -1, -1, 1'b1, 2'b10, 1'b0);

        // Randomized runs with START/D_IN noise during RUN.
        for (int r = 0; r < 20; r++) begin
            int len;
            int rep;
            int ab;
            if ($urandom_range(0, 1) == 1) prog($urandom_range(0, 7), 2'($urandom));
            len = $urandom_range(0, 7);
            rep = $urandom_range(0, 3);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (len + 1) * (rep + 1) - 1) : -1;
            do_run(len, rep, 4'($urandom), ab, -1, 1'($urandom_range(0, 1)), 2'($urandom), 1'b1);
        end

        // Asynchronous reset in the middle of a run.
        prog(1, 2'b10); prog(2, 2'b11);
        START = 1'b1; LEN = 3'd3; REPEAT = 4'd1; D_IN = 4'b0111;
        tick();
        START = 1'b0;
        tick();
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_s", S, 0);
        chk("arst_d", D, 0);
        chk("arst_step", STEP, 0);
        chk("arst_pass", PASS, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_done", DONE, 0);
        chk("arst_aborted", ABORTED, 0);
        for (int i = 0; i < 8; i++) model_mem[i] = 2'b00;
        @(negedge CLK);
        RESET = 1'b1;
        tick();
        chk("post_rst_done", DONE, 0);
        chk("post_rst_aborted", ABORTED, 0);
        chk("post_rst_busy", BUSY, 0);
        do_run(3, 0, 4'b1100, -1, -1, 1'b0, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
